// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag unit and the branch decider.
// Flag bit positions, the flags type, pending-writer state encoding and
// the branch opType/opCode constants live here so both sides agree.
package flag_pkg;

  // Bit positions inside a flags_t value
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  typedef logic [1:0] flags_t;

  // Occupancy classes of the in-flight flag-writer counter
  typedef enum logic [1:0] {
    PEND_EMPTY = 2'd0,
    PEND_BUSY  = 2'd1,
    PEND_FULL  = 2'd2
  } pend_state_t;

  // Branch decider encodings: opType selects the branch class,
  // opCode selects which flag condition is tested
  localparam logic [2:0] OPTYPE_BRANCH = 3'b110;
  localparam logic [2:0] BR_EQ = 3'd0;  // Z
  localparam logic [2:0] BR_NE = 3'd1;  // !Z
  localparam logic [2:0] BR_LT = 3'd2;  // N
  localparam logic [2:0] BR_GE = 3'd3;  // !N
  localparam logic [2:0] BR_AL = 3'd4;  // always

  // Classify a pending count against the configured ceiling
  function automatic pend_state_t pend_state_of(input logic [2:0] p,
                                                input logic [2:0] max_p);
    pend_state_t s;
    if (p == 3'd0)       s = PEND_EMPTY;
    else if (p == max_p) s = PEND_FULL;
    else                 s = PEND_BUSY;
    return s;
  endfunction

endpackage

// File: rtl/flag_gen.sv
// Combinational N/Z flag generation from a writeback ALU result.
module flag_gen
  import flag_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_result,
  output flags_t            o_flags
);

  // N is the sign bit, Z is set for an all-zero result
  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_N] = i_result[DATA_W-1];
    o_flags[FLAG_Z] = (i_result == '0);
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with in-flight writer tracking and branch stall.
// Optional macro FLAG_FORWARD_EN: when defined, the writeback-stage flags
// are forwarded to the flags output and retire the last writer in the same
// cycle, so a waiting branch resolves without the extra register cycle.
//
// Issue handshake: issue_setflags is a request and issue_stall is its
// inverted ready; an issue is accepted only in a cycle where issue_setflags
// is high and issue_stall is low. A request seen while issue_stall is high
// is dropped, so upstream must hold it until issue_stall falls.
module flag_unit
  import flag_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_setflags,
  output logic              issue_stall,
  input  logic              wb_valid,
  input  logic              wb_setflags,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              branch_req,
  output logic              branch_stall,
  output logic [1:0]        flags,
  input  logic              flush,
  output logic              proto_err,
  output logic [2:0]        o_dbg_pending,
  output logic [1:0]        o_dbg_state
);

  localparam logic [2:0] MAX_P = 3'(MAX_PENDING);

  flags_t      r_flags;
  logic [2:0]  r_pend;
  pend_state_t r_state;
  logic        r_perr;

  logic        w_we;
  logic        w_issue_ok;
  flags_t      w_new_flags;
  logic [2:0]  w_p_next;
  logic [2:0]  w_p_eff;

  flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .i_result (wb_result),
    .o_flags  (w_new_flags)
  );

  assign w_we        = wb_valid & wb_setflags;
  assign issue_stall = (r_pend == MAX_P);
  assign w_issue_ok  = issue_setflags & ~issue_stall;

  // Next pending count: flush clears, issue and writeback cancel each other,
  // and a writeback with nothing pending leaves the count at zero
  always_comb begin
    w_p_next = r_pend;
    if (flush) begin
      w_p_next = 3'd0;
    end else if (w_issue_ok && !w_we) begin
      w_p_next = r_pend + 3'd1;
    end else if (!w_issue_ok && w_we && (r_pend != 3'd0)) begin
      w_p_next = r_pend - 3'd1;
    end
  end

  // Counter, its state class, flag register and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 3'd0;
      r_state <= PEND_EMPTY;
      r_flags <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_pend  <= w_p_next;
      r_state <= pend_state_of(w_p_next, MAX_P);
      if (w_we) begin
        r_flags <= w_new_flags;
      end
      if (w_we && (r_pend == 3'd0)) begin
        r_perr <= 1'b1;
      end
    end
  end

`ifdef FLAG_FORWARD_EN
  // Writeback flags bypass the register; the retiring writer no longer counts
  always_comb begin
    flags   = w_we ? w_new_flags : r_flags;
    w_p_eff = r_pend - {2'b00, (w_we && (r_pend != 3'd0))};
  end
`else
  // Only registered flags are visible, so the branch waits for the register
  always_comb begin
    flags   = r_flags;
    w_p_eff = r_pend;
  end
`endif

  assign branch_stall  = branch_req & (w_p_eff != 3'd0);
  assign proto_err     = r_perr;
  assign o_dbg_pending = r_pend;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter DATA_W, default 32, ALU result width.
REQ-002 Parameter MAX_PENDING, default 3, max in-flight flag-writing instructions (1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 issue_setflags  input  1  flag-writing instruction issues this cycle.
REQ-006 issue_stall  output  1  pending count full; upstream holds issue.
REQ-007 wb_valid  input  1  writeback-stage result valid.
REQ-008 wb_setflags  input  1  writeback instruction updates flags.
REQ-009 wb_result  input  DATA_W  writeback ALU result.
REQ-010 branch_req  input  1  decode holds a conditional branch needing flags.
REQ-011 branch_stall  output  1  branch must wait; flags not yet final.
REQ-012 flags  output  2  bit1 negative, bit0 zero; drives branch decider.
REQ-013 flush  input  1  squash all in-flight flag writers.
REQ-014 proto_err  output  1  sticky protocol-error indicator.

Function
REQ-015 Flag write event W = wb_valid & wb_setflags; new flags: N = wb_result[DATA_W-1], Z = (wb_result == 0).
REQ-016 Flag register loads new flags on W, one cycle after W; otherwise holds.
REQ-017 Pending counter P (3 bits) tracks issued-not-written flag writers; states EMPTY (P=0), PENDING (0<P<MAX_PENDING), FULL (P=MAX_PENDING).
REQ-018 issue_stall = (P == MAX_PENDING), combinational; issue_setflags while issue_stall is ignored.
REQ-019 Accepted issue only: P+1; W only: P-1; both same cycle: P unchanged.
REQ-020 W with P=0: flags still loaded, P stays 0, proto_err set.
REQ-021 flush: P<=0 next cycle, overriding same-cycle issue and W for the counter; flag register still loads on same-cycle W.
REQ-022 branch_stall = branch_req & (P_eff != 0); P_eff defined in Configuration; branch_stall is 0 whenever branch_req is 0.
REQ-023 flags output held stable while branch_stall is high, unless a W occurs.

Reset
REQ-024 On rst: flag register 2'b00, P=0, proto_err=0; outputs next cycle: flags=2'b00, issue_stall=0, branch_stall=0.
REQ-025 rst mid-operation discards all pending writers; rst dominates flush, issue and W.

Configuration
REQ-026 Macro FLAG_FORWARD_EN.
REQ-027 Defined: flags = new flags when W, else register; P_eff = P - (W & P!=0), so a branch behind the last writer resolves in the writeback cycle with no stall.
REQ-028 Undefined: flags = register only; P_eff = P, so the branch stalls one extra cycle until the register updates.

Structure
REQ-029 Shared package flag_pkg: FLAG_Z=0 and FLAG_N=1 index constants, flags_t 2-bit typedef, branch opType/opCode constants shared with the branch decider.
REQ-030 One sub-module flag_gen: combinational N/Z from wb_result, parameterised DATA_W.
REQ-031 Counter and stall logic stay in flag_unit.

Verification
REQ-032 Reset, then issue 1, wb_result=0 three cycles later, branch_req held -> branch_stall=1 until W; flags=2'b01; stall drops in W cycle with FLAG_FORWARD_EN, one cycle later without.
REQ-033 wb_result=32'h8000_0000 on W -> flags=2'b10; wb_result=32'h0000_0005 -> flags=2'b00.
REQ-034 Issue 3 back-to-back -> issue_stall=1 at P=3; 4th issue ignored; one W -> P=2, issue_stall=0.
REQ-035 P=2, issue and W same cycle -> P stays 2; flush -> P=0, branch_stall=0 next cycle.
REQ-036 W with P=0, wb_result=0 -> flags=2'b01, proto_err=1, held until rst.
REQ-037 rst asserted with P=2 and branch_req=1 -> next cycle P=0, flags=2'b00, branch_stall=0.
